// File: rtl/segregate_pkg.sv
// Shared constants, state encodings and elaboration helpers for the Segregate game controller.
package segregate_pkg;

  localparam int unsigned DEF_LANES     = 2;
  localparam int unsigned DEF_DEPTH     = 64;
  localparam int unsigned DEF_MAX_WRONG = 3;
  localparam int unsigned DEF_SCORE_W   = 7;

  // Wrong-drop counter is wide enough for the largest legal MAX_WRONG (7).
  localparam int unsigned WCNT_W = 3;

  localparam logic [4:0] ST_I    = 5'b00001;
  localparam logic [4:0] ST_PLAY = 5'b00010;
  localparam logic [4:0] ST_DROP = 5'b00100;
  localparam logic [4:0] ST_SKIP = 5'b01000;
  localparam logic [4:0] ST_DONE = 5'b10000;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  function automatic int unsigned clog2_u(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/segregate_lane.sv
// One bin: fill counter, lit/wrong slot vectors and wrong-drop counter.
module segregate_lane
  import segregate_pkg::*;
#(
  parameter int unsigned DEPTH     = DEF_DEPTH,
  parameter int unsigned MAX_WRONG = DEF_MAX_WRONG,
  parameter int unsigned PW        = clog2_u(DEF_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             drop,
  input  logic             skip,
  input  logic             is_wrong,
  output logic [PW-1:0]    pos,
  output logic [DEPTH-1:0] light,
  output logic [DEPTH-1:0] wrong,
  output logic             full_c,
  output logic             wrong_max_c
);

  localparam int unsigned AW = PW - 1;

  logic [PW-1:0]     pos_q, pos_d;
  logic [DEPTH-1:0]  light_q, light_d;
  logic [DEPTH-1:0]  wrong_q, wrong_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;

  // Slot index is the low bits of pos; the top FSM never drops into a full lane.
  always_comb begin
    pos_d   = pos_q;
    light_d = light_q;
    wrong_d = wrong_q;
    wcnt_d  = wcnt_q;
    if (clr) begin
      pos_d   = '0;
      light_d = '0;
      wrong_d = '0;
      wcnt_d  = '0;
    end else if (drop) begin
      light_d[pos_q[AW-1:0]] = 1'b1;
      pos_d = pos_q + PW'(1);
      if (is_wrong) begin
        wrong_d[pos_q[AW-1:0]] = 1'b1;
        wcnt_d = wcnt_q + WCNT_W'(1);
      end
    end else if (skip) begin
      pos_d = pos_q + PW'(1);
    end
  end

  // Flags look at the post-update values so the FSM can leave DROP/SKIP straight into DONE.
  assign full_c      = (pos_d == PW'(DEPTH));
  assign wrong_max_c = (wcnt_d == WCNT_W'(MAX_WRONG));

  always_ff @(posedge clk) begin
    if (reset) begin
      pos_q   <= '0;
      light_q <= '0;
      wrong_q <= '0;
      wcnt_q  <= '0;
    end else begin
      pos_q   <= pos_d;
      light_q <= light_d;
      wrong_q <= wrong_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign pos   = pos_q;
  assign light = light_q;
  assign wrong = wrong_q;

endmodule

// File: rtl/segregate_fsm_multi.sv
// Segregate game controller for LANES bins: game FSM, lane select, score/best and item category.
module segregate_fsm_multi
  import segregate_pkg::*;
#(
  parameter  int unsigned LANES     = DEF_LANES,
  parameter  int unsigned DEPTH     = DEF_DEPTH,
  parameter  int unsigned MAX_WRONG = DEF_MAX_WRONG,
  parameter  int unsigned SCORE_W   = DEF_SCORE_W,
  localparam int unsigned PW        = clog2_u(DEPTH) + 1,
  localparam int unsigned CW        = max_u(1, clog2_u(LANES))
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   Start,
  input  logic                   Ack,
  input  logic                   Pulse,
  input  logic [LANES-1:0]       Btn,
  input  logic [CW-1:0]          rand_cat,
  output logic [CW-1:0]          cur_cat,
  output logic [LANES*PW-1:0]    pos,
  output logic [LANES*DEPTH-1:0] light,
  output logic [LANES*DEPTH-1:0] wrong,
  output logic [SCORE_W-1:0]     score,
  output logic [SCORE_W-1:0]     best,
  output logic                   q_I,
  output logic                   q_Play,
  output logic                   q_Drop,
  output logic                   q_Skip,
  output logic                   q_Done
);

  logic [4:0]         state_q, state_d;
  logic [CW-1:0]      sel_q, sel_d;
  logic [CW-1:0]      cur_cat_q, cur_cat_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W-1:0] best_q, best_d;
  logic               done_entry_q, done_entry_d;

  logic [CW-1:0]      rand_clamp_c;
  logic [CW-1:0]      btn_sel_c;
  logic [LANES-1:0]   lane_full_c;
  logic [LANES-1:0]   lane_wmax_c;
  logic [LANES-1:0]   lane_drop_c;
  logic [LANES-1:0]   lane_skip_c;
  logic               lane_clr_c;
  logic               is_wrong_c;

  // Categories beyond the last lane fold onto it.
  always_comb begin
    rand_clamp_c = rand_cat;
    if (32'(rand_cat) >= LANES) rand_clamp_c = CW'(LANES - 1);
  end

  // Lowest-index pressed button wins.
  always_comb begin
    btn_sel_c = '0;
    for (int i = int'(LANES) - 1; i >= 0; i--) begin
      if (Btn[i]) btn_sel_c = CW'(i);
    end
  end

  assign lane_clr_c = (state_q == ST_I);
  assign is_wrong_c = (sel_q != cur_cat_q);

  always_comb begin
    lane_drop_c = '0;
    lane_skip_c = '0;
    for (int l = 0; l < int'(LANES); l++) begin
      lane_drop_c[l] = (state_q == ST_DROP) && (sel_q == CW'(l));
      lane_skip_c[l] = (state_q == ST_SKIP) && (cur_cat_q == CW'(l));
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    cur_cat_d = cur_cat_q;
    score_d   = score_q;
    best_d    = best_q;
    case (state_q)
      ST_I: begin
        cur_cat_d = rand_clamp_c;
        score_d   = '0;
        if (Start) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        if (|Btn) begin
          sel_d   = btn_sel_c;
          state_d = ST_DROP;
        end else if (Pulse) begin
          state_d = ST_SKIP;
        end
      end
      ST_DROP: begin
        if ((sel_q == cur_cat_q) && (score_q != '1)) score_d = score_q + SCORE_W'(1);
        cur_cat_d = rand_clamp_c;
        state_d   = (lane_full_c[sel_q] || lane_wmax_c[sel_q]) ? ST_DONE : ST_PLAY;
      end
      ST_SKIP: begin
        cur_cat_d = rand_clamp_c;
        state_d   = lane_full_c[cur_cat_q] ? ST_DONE : ST_PLAY;
      end
      ST_DONE: begin
        // Score is final by the first DONE cycle; best is committed once, on that cycle.
        if (done_entry_q && (score_q > best_q)) best_d = score_q;
        if (Ack) state_d = ST_I;
      end
      default: state_d = ST_I;
    endcase
  end

  assign done_entry_d = (state_d == ST_DONE) && (state_q != ST_DONE);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= ST_I;
      sel_q        <= '0;
      cur_cat_q    <= '0;
      score_q      <= '0;
      best_q       <= '0;
      done_entry_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      cur_cat_q    <= cur_cat_d;
      score_q      <= score_d;
      best_q       <= best_d;
      done_entry_q <= done_entry_d;
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    segregate_lane #(
      .DEPTH     (DEPTH),
      .MAX_WRONG (MAX_WRONG),
      .PW        (PW)
    ) u_lane (
      .clk         (Clk),
      .reset       (Reset),
      .clr         (lane_clr_c),
      .drop        (lane_drop_c[l]),
      .skip        (lane_skip_c[l]),
      .is_wrong    (is_wrong_c),
      .pos         (pos[l*PW +: PW]),
      .light       (light[l*DEPTH +: DEPTH]),
      .wrong       (wrong[l*DEPTH +: DEPTH]),
      .full_c      (lane_full_c[l]),
      .wrong_max_c (lane_wmax_c[l])
    );
  end

  assign cur_cat = cur_cat_q;
  assign score   = score_q;
  assign best    = best_q;

  assign q_I    = (state_q == ST_I);
  assign q_Play = (state_q == ST_PLAY);
  assign q_Drop = (state_q == ST_DROP);
  assign q_Skip = (state_q == ST_SKIP);
  assign q_Done = (state_q == ST_DONE);

endmodule

// File: tb/tb_segregate_fsm_multi.sv
// Directed bench for segregate_fsm_multi: LANES=3, DEPTH=8, MAX_WRONG=2, plus a 3-bit-score copy.
module tb_segregate_fsm_multi;

  logic        clk;
  logic        rst;
  logic        start;
  logic        ack;
  logic        pulse;
  logic [2:0]  btn;
  logic [1:0]  rnd;

  logic [1:0]  cur_cat;
  logic [11:0] pos;
  logic [23:0] light;
  logic [23:0] wrong;
  logic [6:0]  score;
  logic [6:0]  best;
  logic        q_i, q_play, q_drop, q_skip, q_done;

  logic [1:0]  cur_cat_s;
  logic [11:0] pos_s;
  logic [23:0] light_s;
  logic [23:0] wrong_s;
  logic [2:0]  score_s;
  logic [2:0]  best_s;
  logic        qs_i, qs_play, qs_drop, qs_skip, qs_done;

  int total = 0;
  int bad   = 0;

  segregate_fsm_multi #(.LANES(3), .DEPTH(8), .MAX_WRONG(2), .SCORE_W(7)) dut (
    .Clk(clk), .Reset(rst), .Start(start), .Ack(ack), .Pulse(pulse), .Btn(btn),
    .rand_cat(rnd), .cur_cat(cur_cat), .pos(pos), .light(light), .wrong(wrong),
    .score(score), .best(best), .q_I(q_i), .q_Play(q_play), .q_Drop(q_drop),
    .q_Skip(q_skip), .q_Done(q_done)
  );

  segregate_fsm_multi #(.LANES(3), .DEPTH(8), .MAX_WRONG(2), .SCORE_W(3)) dut_s (
    .Clk(clk), .Reset(rst), .Start(start), .Ack(ack), .Pulse(pulse), .Btn(btn),
    .rand_cat(rnd), .cur_cat(cur_cat_s), .pos(pos_s), .light(light_s), .wrong(wrong_s),
    .score(score_s), .best(best_s), .q_I(qs_i), .q_Play(qs_play), .q_Drop(qs_drop),
    .q_Skip(qs_skip), .q_Done(qs_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [4:0] S_I = 5'h01, S_PLAY = 5'h02, S_DROP = 5'h04, S_SKIP = 5'h08, S_DONE = 5'h10;

  typedef struct {
    logic        start;
    logic        ack;
    logic        pulse;
    logic [2:0]  btn;
    logic [1:0]  rnd;
    logic [4:0]  st;
    logic [1:0]  cc;
    logic [11:0] pos;
    logic [23:0] light;
    logic [23:0] wrong;
    logic [6:0]  score;
    logic [6:0]  best;
  } vec_t;

  vec_t tbl[22];

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [4:0] st_main();
    return {q_done, q_skip, q_drop, q_play, q_i};
  endfunction

  function automatic logic [4:0] st_sat();
    return {qs_done, qs_skip, qs_drop, qs_play, qs_i};
  endfunction

  task automatic check_all(input string tag, input logic [4:0] st, input logic [1:0] cc,
                           input logic [11:0] p, input logic [23:0] li, input logic [23:0] wr,
                           input logic [6:0] sc, input logic [6:0] be);
    check({tag, ".state"}, 64'(st_main()), 64'(st));
    check({tag, ".cur_cat"}, 64'(cur_cat), 64'(cc));
    check({tag, ".pos"}, 64'(pos), 64'(p));
    check({tag, ".light"}, 64'(light), 64'(li));
    check({tag, ".wrong"}, 64'(wrong), 64'(wr));
    check({tag, ".score"}, 64'(score), 64'(sc));
    check({tag, ".best"}, 64'(best), 64'(be));
  endtask

  task automatic idle_inputs();
    start = 1'b0; ack = 1'b0; pulse = 1'b0; btn = 3'b000;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    rnd = 2'd0;

    //          start ack  pulse btn     rnd    state   cc     pos      light      wrong      score best
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 3'b000, 2'd1, S_PLAY, 2'd1, 12'h000, 24'h000000, 24'h000000, 7'd0, 7'd0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 3'b010, 2'd1, S_DROP, 2'd1, 12'h000, 24'h000000, 24'h000000, 7'd0, 7'd0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 3'b000, 2'd0, S_PLAY, 2'd0, 12'h010, 24'h000100, 24'h000000, 7'd1, 7'd0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 3'b100, 2'd0, S_DROP, 2'd0, 12'h010, 24'h000100, 24'h000000, 7'd1, 7'd0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 3'b000, 2'd0, S_PLAY, 2'd0, 12'h110, 24'h010100, 24'h010000, 7'd1, 7'd0};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 3'b110, 2'd2, S_DROP, 2'd0, 12'h110, 24'h010100, 24'h010000, 7'd1, 7'd0};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 3'b000, 2'd2, S_PLAY, 2'd2, 12'h120, 24'h010300, 24'h010200, 7'd1, 7'd0};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 3'b000, 2'd3, S_SKIP, 2'd2, 12'h120, 24'h010300, 24'h010200, 7'd1, 7'd0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 3'b000, 2'd3, S_PLAY, 2'd2, 12'h220, 24'h010300, 24'h010200, 7'd1, 7'd0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 3'b100, 2'd1, S_DROP, 2'd2, 12'h220, 24'h010300, 24'h010200, 7'd1, 7'd0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 3'b000, 2'd1, S_PLAY, 2'd1, 12'h320, 24'h050300, 24'h010200, 7'd2, 7'd0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 3'b001, 2'd1, S_DROP, 2'd1, 12'h320, 24'h050300, 24'h010200, 7'd2, 7'd0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 3'b000, 2'd1, S_PLAY, 2'd1, 12'h321, 24'h050301, 24'h010201, 7'd2, 7'd0};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 3'b010, 2'd1, S_DROP, 2'd1, 12'h321, 24'h050301, 24'h010201, 7'd2, 7'd0};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 3'b000, 2'd1, S_PLAY, 2'd1, 12'h331, 24'h050701, 24'h010201, 7'd3, 7'd0};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 3'b001, 2'd1, S_DROP, 2'd1, 12'h331, 24'h050701, 24'h010201, 7'd3, 7'd0};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 3'b000, 2'd1, S_DONE, 2'd1, 12'h332, 24'h050703, 24'h010203, 7'd3, 7'd0};
    tbl[17] = '{1'b0, 1'b0, 1'b0, 3'b000, 2'd1, S_DONE, 2'd1, 12'h332, 24'h050703, 24'h010203, 7'd3, 7'd3};
    tbl[18] = '{1'b1, 1'b0, 1'b1, 3'b001, 2'd1, S_DONE, 2'd1, 12'h332, 24'h050703, 24'h010203, 7'd3, 7'd3};
    tbl[19] = '{1'b0, 1'b1, 1'b0, 3'b000, 2'd2, S_I,    2'd1, 12'h332, 24'h050703, 24'h010203, 7'd3, 7'd3};
    tbl[20] = '{1'b0, 1'b0, 1'b0, 3'b000, 2'd2, S_I,    2'd2, 12'h000, 24'h000000, 24'h000000, 7'd0, 7'd3};
    tbl[21] = '{1'b0, 1'b1, 1'b0, 3'b000, 2'd2, S_I,    2'd2, 12'h000, 24'h000000, 24'h000000, 7'd0, 7'd3};

    // Reset state
    tick();
    rst = 1'b0;
    check_all("reset", S_I, 2'd0, 12'h000, 24'h0, 24'h0, 7'd0, 7'd0);

    // Table: correct/wrong drops, Btn-over-Pulse, clamped skip, wrong-limit DONE, best, Ack
    for (int i = 0; i < 22; i++) begin
      start = tbl[i].start; ack = tbl[i].ack; pulse = tbl[i].pulse;
      btn = tbl[i].btn; rnd = tbl[i].rnd;
      tick();
      check_all($sformatf("row%0d", i), tbl[i].st, tbl[i].cc, tbl[i].pos, tbl[i].light,
                tbl[i].wrong, tbl[i].score, tbl[i].best);
    end
    idle_inputs();

    // Fill lane 0 with eight correct drops
    rnd = 2'd0; start = 1'b1;
    tick();
    start = 1'b0;
    check("fill.start_cat", 64'(cur_cat), 64'd0);
    for (int k = 1; k <= 8; k++) begin
      btn = 3'b001;
      tick();
      btn = 3'b000;
      check($sformatf("fill%0d.drop_state", k), 64'(st_main()), 64'(S_DROP));
      tick();
      check_all($sformatf("fill%0d", k), (k < 8) ? S_PLAY : S_DONE, 2'd0, 12'(k),
                24'((32'd1 << k) - 1), 24'h0, 7'(k), 7'd3);
    end
    tick();
    check("fill.best_late", 64'(best), 64'd8);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("fill.ack_state", 64'(st_main()), 64'(S_I));
    check("fill.ack_score_held", 64'(score), 64'd8);
    rnd = 2'd3;
    tick();
    check_all("fill.cleared", S_I, 2'd2, 12'h000, 24'h0, 24'h0, 7'd0, 7'd8);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_all("fill.restart", S_PLAY, 2'd2, 12'h000, 24'h0, 24'h0, 7'd0, 7'd8);

    // Eight timeouts fill lane 2 with unlit slots and end the game
    for (int k = 1; k <= 8; k++) begin
      pulse = 1'b1;
      tick();
      pulse = 1'b0;
      check($sformatf("skip%0d.state", k), 64'(st_main()), 64'(S_SKIP));
      tick();
      check_all($sformatf("skip%0d", k), (k < 8) ? S_PLAY : S_DONE, 2'd2, 12'(k << 8),
                24'h0, 24'h0, 7'd0, 7'd8);
    end
    tick();
    check("skip.best_kept", 64'(best), 64'd8);
    ack = 1'b1;
    tick();
    ack = 1'b0;

    // Reset in the middle of a DROP
    rnd = 2'd1; start = 1'b1;
    tick();
    start = 1'b0;
    btn = 3'b010;
    tick();
    btn = 3'b000;
    tick();
    check("rstdrop.score_before", 64'(score), 64'd1);
    btn = 3'b010;
    tick();
    btn = 3'b000;
    check("rstdrop.in_drop", 64'(st_main()), 64'(S_DROP));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all("rstdrop", S_I, 2'd0, 12'h000, 24'h0, 24'h0, 7'd0, 7'd0);

    // Ten correct drops round-robin: 7-bit score counts on, 3-bit score saturates
    rnd = 2'd0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      btn = 3'(1 << (i % 3));
      rnd = 2'((i + 1) % 3);
      tick();
      btn = 3'b000;
      tick();
      check($sformatf("sat%0d.score7", i), 64'(score), 64'(i + 1));
      check($sformatf("sat%0d.score3", i), 64'(score_s), 64'((i < 7) ? i + 1 : 7));
      check($sformatf("sat%0d.state3", i), 64'(st_sat()), 64'(S_PLAY));
    end
    check("sat.pos3", 64'(pos_s), 64'h334);
    check("sat.light3", 64'(light_s), 64'h07070F);
    check("sat.wrong3", 64'(wrong_s), 64'h0);
    check("sat.cur_cat3", 64'(cur_cat_s), 64'd1);
    check("sat.best3", 64'(best_s), 64'd0);
    check_all("sat.main", S_PLAY, 2'd1, 12'h334, 24'h07070F, 24'h0, 7'd10, 7'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
